// File: rtl/led_flow_pkg.sv
// Shared mode encodings and FSM state type for the LED running-light sequencer.
// No logic here; latency and backpressure are properties of the users.
package led_flow_pkg;

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  localparam int LED_N_MIN = 2;
  localparam int LED_N_MAX = 32;

endpackage

// File: rtl/led_flow_ctrl_if.sv
// Step source, switch inputs and pattern/strobe outputs of led_flow_ctrl.
// Purely combinational bundle: no latency, no backpressure.
interface led_flow_ctrl_if #(
  parameter int LED_N = 8
);

  logic             Step_In;
  logic [1:0]       Mode;
  logic             Run;
  logic [LED_N-1:0] LED;
  logic             Step_Pulse;
  logic             Wrap;

  modport master (
    output Step_In, Mode, Run,
    input  LED, Step_Pulse, Wrap
  );

  modport slave (
    input  Step_In, Mode, Run,
    output LED, Step_Pulse, Wrap
  );

endinterface

// File: rtl/step_sync.sv
// Rising-edge detector for Step_In, optionally behind a 2-flop synchronizer (LED_SYNC_EN).
// Latency: rise is combinational from the last stage; 2 extra edges with LED_SYNC_EN. No backpressure.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step_in,
  output logic rise
);

`ifdef LED_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = step_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign rise = sync2_q & ~dly_q;
`else
  logic dly_q, dly_d;

  always_comb begin
    dly_d = step_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
    end
  end

  // dly_q clears on reset, so a Step_In already high at release is one step.
  assign rise = step_in & ~dly_q;
`endif

endmodule

// File: rtl/led_flow_ctrl.sv
// Running-light sequencer: each Step_In rising edge reloads or advances a rotate/ping-pong/bar pattern.
// Outputs registered one edge after the detected rise (2 more with LED_SYNC_EN); no backpressure.
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int LED_N = 8  // legal range LED_N_MIN..LED_N_MAX
) (
  input  logic           CLK_50M,
  input  logic           nCR,
  led_flow_ctrl_if.slave bus
);

  logic             rise;
  mode_e            mode_in;
  logic             apply;

  state_e           state_q, state_d;
  mode_e            cur_mode_q, cur_mode_d;
  logic             dir_q, dir_d;  // 0 = toward bit LED_N-1
  logic [LED_N-1:0] led_q, led_d;
  logic             step_pulse_q, step_pulse_d;
  logic             wrap_q, wrap_d;

  function automatic logic [LED_N-1:0] seed_of(input mode_e m);
    logic [LED_N-1:0] s;
    s = '0;
    if (m == MODE_ROR) s[LED_N-1] = 1'b1;
    else               s[0]       = 1'b1;
    return s;
  endfunction

  step_sync u_step_sync (
    .clk     (CLK_50M),
    .rst_n   (nCR),
    .step_in (bus.Step_In),
    .rise    (rise)
  );

  assign mode_in = mode_e'(bus.Mode);

  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    dir_d        = dir_q;
    led_d        = led_q;
    step_pulse_d = rise;
    wrap_d       = 1'b0;
    apply        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise && bus.Run) begin
          led_d      = seed_of(mode_in);
          cur_mode_d = mode_in;
          dir_d      = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // A step in the same cycle Run falls is dropped.
        if (!bus.Run)  state_d = S_HOLD;
        else if (rise) apply   = 1'b1;
      end
      S_HOLD: begin
        if (rise && bus.Run) begin
          apply   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (apply) begin
      if (mode_in != cur_mode_q) begin
        led_d      = seed_of(mode_in);
        cur_mode_d = mode_in;
        dir_d      = 1'b0;
      end else begin
        case (cur_mode_q)
          MODE_ROL: begin
            led_d  = {led_q[LED_N-2:0], led_q[LED_N-1]};
            wrap_d = led_q[LED_N-1];
          end
          MODE_ROR: begin
            led_d  = {led_q[0], led_q[LED_N-1:1]};
            wrap_d = led_q[0];
          end
          MODE_PING: begin
            // Direction flips on arriving at an end bit, so each end is lit once per period.
            if (!dir_q) begin
              led_d = led_q << 1;
              if (led_q[LED_N-2]) dir_d = 1'b1;
            end else begin
              led_d = led_q >> 1;
              if (led_q[1]) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end
            end
          end
          default: begin
            if (&led_q) begin
              led_d  = seed_of(MODE_BAR);
              wrap_d = 1'b1;
            end else begin
              led_d = {led_q[LED_N-2:0], 1'b1};
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge nCR) begin
    if (!nCR) begin
      state_q      <= S_IDLE;
      cur_mode_q   <= MODE_ROL;
      dir_q        <= 1'b0;
      led_q        <= '0;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_mode_q   <= cur_mode_d;
      dir_q        <= dir_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.LED        = led_q;
  assign bus.Step_Pulse = step_pulse_q;
  assign bus.Wrap       = wrap_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (LED_N=8); step latency follows LED_SYNC_EN.
module tb_led_flow_ctrl;

`ifdef LED_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic nCR;
  int   checks    = 0;
  int   failures  = 0;
  int   pulse_cnt = 0;
  int   snap;

  always #5 clk = ~clk;

  led_flow_ctrl_if #(.LED_N(8)) bus ();

  led_flow_ctrl #(.LED_N(8)) dut (
    .CLK_50M (clk),
    .nCR     (nCR),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.Step_Pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full step: raise Step_In, check outputs when they land, drop it, check strobes clear.
  task automatic step(input string tag, input logic [7:0] exp_led, input logic exp_wrap);
    @(negedge clk) bus.Step_In = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check($sformatf("%s_led", tag), 32'(bus.LED), 32'(exp_led));
    check($sformatf("%s_pulse", tag), 32'(bus.Step_Pulse), 32'd1);
    check($sformatf("%s_wrap", tag), 32'(bus.Wrap), 32'(exp_wrap));
    bus.Step_In = 1'b0;
    @(negedge clk);
    check($sformatf("%s_pulse_off", tag), 32'(bus.Step_Pulse), 32'd0);
    check($sformatf("%s_wrap_off", tag), 32'(bus.Wrap), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] one;
    logic [8:0] bar;
    int         pos;
    one         = 8'h01;
    nCR         = 1'b0;
    bus.Step_In = 1'b0;
    bus.Mode    = 2'b00;
    bus.Run     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_led", 32'(bus.LED), 32'd0);
    check("rst_pulse", 32'(bus.Step_Pulse), 32'd0);
    check("rst_wrap", 32'(bus.Wrap), 32'd0);
    nCR = 1'b1;

    // Rotate-left from idle: seed then advance, wrap on the 9th step.
    bus.Run  = 1'b1;
    bus.Mode = 2'b00;
    for (int i = 0; i < 9; i++)
      step($sformatf("rol%0d", i), one << (i % 8), i == 8);

    // Ping-pong: reload to 01, out to 80 and back, wrap on the 15th step.
    bus.Mode = 2'b10;
    for (int i = 0; i < 15; i++) begin
      pos = (i <= 7) ? i : 14 - i;
      step($sformatf("ping%0d", i), one << pos, i == 14);
    end

    // Bar graph: 01..FF then back to 01 with wrap.
    bus.Mode = 2'b11;
    for (int i = 0; i < 9; i++) begin
      bar = (9'd1 << (i + 1)) - 9'd1;
      step($sformatf("bar%0d", i), (i == 8) ? 8'h01 : bar[7:0], i == 8);
    end

    // Mode switch mid-sequence reloads without wrap; no effect until a step.
    bus.Mode = 2'b00;
    step("sw_a", 8'h01, 1'b0);
    step("sw_b", 8'h02, 1'b0);
    step("sw_c", 8'h04, 1'b0);
    step("sw_d", 8'h08, 1'b0);
    bus.Mode = 2'b01;
    repeat (3) @(negedge clk);
    check("sw_nostep_led", 32'(bus.LED), 32'h08);
    step("sw_ror_seed", 8'h80, 1'b0);
    step("sw_ror_adv", 8'h40, 1'b0);

    // Hold: steps pulse but LED freezes; resuming advances from the frozen value.
    bus.Mode = 2'b00;
    step("hold_a", 8'h01, 1'b0);
    step("hold_b", 8'h02, 1'b0);
    step("hold_c", 8'h04, 1'b0);
    @(negedge clk) bus.Run = 1'b0;
    repeat (2) @(negedge clk);
    snap = pulse_cnt;
    for (int i = 0; i < 5; i++)
      step($sformatf("held%0d", i), 8'h04, 1'b0);
    check("held_pulse_count", 32'(pulse_cnt - snap), 32'd5);
    bus.Run = 1'b1;
    step("resume", 8'h08, 1'b0);

    // Async reset with Step_In high: LED clears at once; release counts one step.
    @(negedge clk) bus.Step_In = 1'b1;
    #2 nCR = 1'b0;
    #1;
    check("arst_led", 32'(bus.LED), 32'd0);
    check("arst_pulse", 32'(bus.Step_Pulse), 32'd0);
    @(negedge clk);
    snap = pulse_cnt;
    nCR  = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("rel_led", 32'(bus.LED), 32'h01);
    check("rel_pulse", 32'(bus.Step_Pulse), 32'd1);
    check("rel_wrap", 32'(bus.Wrap), 32'd0);
    repeat (10) @(negedge clk);
    check("rel_held_one_step", 32'(pulse_cnt - snap), 32'd1);
    check("rel_held_led", 32'(bus.LED), 32'h01);
    bus.Step_In = 1'b0;
    repeat (4) @(negedge clk);
    step("rel_next", 8'h02, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
